// File: rtl/mouse_roi_select.sv
// Drag-to-select region of interest from the decoded mouse stream, with registered
// rubber-band box and crosshair overlay bits for the VGA mixer.
module mouse_roi_select #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned MIN_SIZE   = 4,
    parameter int unsigned CURSOR_ARM = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] mouse_x_pixel,
    input  logic [9:0] mouse_y_pixel,
    input  logic       click_l,
    input  logic       click_r,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_valid,
    output logic [9:0] roi_x0,
    output logic [9:0] roi_y0,
    output logic [9:0] roi_x1,
    output logic [9:0] roi_y1,
    output logic [9:0] roi_cx,
    output logic [9:0] roi_cy,
    output logic       roi_valid,
    output logic       roi_update,
    output logic       dragging,
    output logic       overlay_box,
    output logic       overlay_cursor
);

    localparam logic [9:0]  XMax  = 10'(H_RES - 1);
    localparam logic [9:0]  YMax  = 10'(V_RES - 1);
    localparam logic [9:0]  MinSz = 10'(MIN_SIZE);
    localparam logic [10:0] ArmW  = 11'(CURSOR_ARM);

    typedef enum logic [1:0] {StIdle, StDrag, StArmed} state_e;

    state_e     state_q, state_d;
    logic       click_l_q, click_r_q;
    logic [9:0] ax_q, ax_d, ay_q, ay_d;
    logic [9:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic       valid_q, valid_d, update_q, update_d;
    logic       box_q, box_d, cursor_q, cursor_d;

    logic [9:0] mx, my;
    logic       rise_l, fall_l, rise_r;
    logic [9:0] dx, dy;
    logic [9:0] band_x0, band_x1, band_y0, band_y1;

    always_comb begin
        mx = (mouse_x_pixel > XMax) ? XMax : mouse_x_pixel;
        my = (mouse_y_pixel > YMax) ? YMax : mouse_y_pixel;
    end

    assign rise_l = click_l & ~click_l_q;
    assign fall_l = ~click_l & click_l_q;
    assign rise_r = click_r & ~click_r_q;

    always_comb begin
        dx      = (mx >= ax_q) ? (mx - ax_q) : (ax_q - mx);
        dy      = (my >= ay_q) ? (my - ay_q) : (ay_q - my);
        band_x0 = (mx < ax_q) ? mx : ax_q;
        band_x1 = (mx < ax_q) ? ax_q : mx;
        band_y0 = (my < ay_q) ? my : ay_q;
        band_y1 = (my < ay_q) ? ay_q : my;
    end

    always_comb begin
        state_d  = state_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        // Right-button rise wins over any left-button activity in the same cycle.
        if (rise_r) begin
            state_d = StIdle;
            x0_d    = '0;
            y0_d    = '0;
            x1_d    = '0;
            y1_d    = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StArmed: begin
                    if (rise_l && !click_r) begin
                        ax_d    = mx;
                        ay_d    = my;
                        state_d = StDrag;
                    end
                end
                StDrag: begin
                    if (fall_l) begin
                        if (dx >= MinSz && dy >= MinSz) begin
                            x0_d     = band_x0;
                            x1_d     = band_x1;
                            y0_d     = band_y0;
                            y1_d     = band_y1;
                            valid_d  = 1'b1;
                            update_d = 1'b1;
                            state_d  = StArmed;
                        end else begin
                            state_d = valid_q ? StArmed : StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    logic       ob_en;
    logic [9:0] ob_x0, ob_x1, ob_y0, ob_y1;
    logic [10:0] cdx, cdy, cadx, cady;

    always_comb begin
        ob_en = 1'b0;
        ob_x0 = '0;
        ob_x1 = '0;
        ob_y0 = '0;
        ob_y1 = '0;
        if (state_q == StDrag) begin
            ob_en = 1'b1;
            ob_x0 = band_x0;
            ob_x1 = band_x1;
            ob_y0 = band_y0;
            ob_y1 = band_y1;
        end else if (state_q == StArmed) begin
            ob_en = 1'b1;
            ob_x0 = x0_q;
            ob_x1 = x1_q;
            ob_y0 = y0_q;
            ob_y1 = y1_q;
        end
    end

    // Signed 11-bit distances keep the crosshair from wrapping at the screen edge.
    always_comb begin
        cdx  = {1'b0, pix_x} - {1'b0, mx};
        cdy  = {1'b0, pix_y} - {1'b0, my};
        cadx = cdx[10] ? (11'd0 - cdx) : cdx;
        cady = cdy[10] ? (11'd0 - cdy) : cdy;
    end

    always_comb begin
        box_d = pix_valid && ob_en &&
                ((((pix_x == ob_x0) || (pix_x == ob_x1)) && (pix_y >= ob_y0) && (pix_y <= ob_y1)) ||
                 (((pix_y == ob_y0) || (pix_y == ob_y1)) && (pix_x >= ob_x0) && (pix_x <= ob_x1)));
        cursor_d = pix_valid &&
                   (((pix_x == mx) && (cady <= ArmW)) || ((pix_y == my) && (cadx <= ArmW)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            click_l_q <= 1'b0;
            click_r_q <= 1'b0;
            ax_q      <= '0;
            ay_q      <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            valid_q   <= 1'b0;
            update_q  <= 1'b0;
            box_q     <= 1'b0;
            cursor_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            click_l_q <= click_l;
            click_r_q <= click_r;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            valid_q   <= valid_d;
            update_q  <= update_d;
            box_q     <= box_d;
            cursor_q  <= cursor_d;
        end
    end

    logic [10:0] sum_x, sum_y;
    assign sum_x = {1'b0, x0_q} + {1'b0, x1_q};
    assign sum_y = {1'b0, y0_q} + {1'b0, y1_q};

    assign roi_x0         = x0_q;
    assign roi_y0         = y0_q;
    assign roi_x1         = x1_q;
    assign roi_y1         = y1_q;
    assign roi_cx         = sum_x[10:1];
    assign roi_cy         = sum_y[10:1];
    assign roi_valid      = valid_q;
    assign roi_update     = update_q;
    assign dragging       = (state_q == StDrag);
    assign overlay_box    = box_q;
    assign overlay_cursor = cursor_q;

endmodule
